// File: rtl/led_matrix_pkg.sv
// led_matrix_pkg: shared sizes and scan-state encoding for the LED matrix controller
package led_matrix_pkg;
    localparam int NUM_ROWS = 16;
    localparam int NUM_COLS = 16;
    localparam int COL_W    = 4;
    localparam int BTN_W    = 3;

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        SHIFT_LO,
        SHIFT_HI,
        SETTLE,
        DISPLAY
    } scan_state_e;
endpackage

// File: rtl/btn_debounce.sv
// btn_debounce: synchronizes the CPLD button code and accepts it after DEBOUNCE equal frame samples
module btn_debounce
    import led_matrix_pkg::*;
#(
    parameter int DEBOUNCE = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             sample,
    input  logic [BTN_W-1:0] code_in,
    output logic [BTN_W-1:0] code,
    output logic             valid
);
    localparam int CNT_W = $clog2(DEBOUNCE + 1);

    logic [BTN_W-1:0] sync1_q, sync2_q;
    logic [BTN_W-1:0] cand_q, cand_d;
    logic [BTN_W-1:0] code_q, code_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             valid_q, valid_d;

    always_comb begin
        cand_d  = cand_q;
        cnt_d   = cnt_q;
        code_d  = code_q;
        valid_d = 1'b0;
        if (sample) begin
            cand_d = sync2_q;
            cnt_d  = (sync2_q != cand_q) ? CNT_W'(1) :
                     (cnt_q == CNT_W'(DEBOUNCE)) ? cnt_q : cnt_q + 1'b1;
        end
        if (cnt_d == CNT_W'(DEBOUNCE) && cand_d != code_q) begin
            code_d  = cand_d;
            valid_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q <= '0;
            sync2_q <= '0;
            cand_q  <= '0;
            cnt_q   <= '0;
            code_q  <= '0;
            valid_q <= 1'b0;
        end else begin
            sync1_q <= code_in;
            sync2_q <= sync1_q;
            cand_q  <= cand_d;
            cnt_q   <= cnt_d;
            code_q  <= code_d;
            valid_q <= valid_d;
        end
    end

    assign code  = code_q;
    assign valid = valid_q;
endmodule

// File: rtl/led_scan_ctrl.sv
// led_scan_ctrl: frame buffer plus column scan FSM that shifts each row word MSB first into the
// CPLD row register, then lights that column for DWELL cycles; debounces buttons once per frame.
module led_scan_ctrl
    import led_matrix_pkg::*;
#(
    parameter int CLK_DIV  = 2,
    parameter int DWELL    = 1024,
    parameter int DEBOUNCE = 4
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                enable,
    input  logic                wr_en,
    input  logic [COL_W-1:0]    wr_col,
    input  logic [NUM_ROWS-1:0] wr_data,
    output logic                row_clk,
    output logic                row_data,
    output logic [COL_W-1:0]    column,
    output logic                column_en,
    input  logic [BTN_W-1:0]    button_code_in,
    output logic [BTN_W-1:0]    button_code,
    output logic                button_valid,
    output logic                frame_done
);
    localparam int DIV_W = $clog2(CLK_DIV + 1);
    localparam int DWL_W = $clog2(DWELL + 1);
    localparam int BIT_W = $clog2(NUM_ROWS);

    scan_state_e         state_q, state_d;
    logic [COL_W-1:0]    col_q, col_d;
    logic [COL_W-1:0]    column_q, column_d;
    logic [NUM_ROWS-1:0] shreg_q, shreg_d;
    logic [BIT_W-1:0]    bit_q, bit_d;
    logic [DIV_W-1:0]    div_q, div_d;
    logic [DWL_W-1:0]    dwell_q, dwell_d;
    logic [NUM_ROWS-1:0] fb_q [NUM_COLS];
    logic [NUM_ROWS-1:0] fb_d [NUM_COLS];
    logic                row_clk_q, row_clk_d;
    logic                row_data_q, row_data_d;
    logic                column_en_q, column_en_d;
    logic                frame_done_q, frame_done_d;
    logic                div_done, dwell_done;

    assign div_done   = div_q == DIV_W'(CLK_DIV - 1);
    assign dwell_done = dwell_q == DWL_W'(DWELL - 1);

    always_comb begin
        state_d      = state_q;
        col_d        = col_q;
        column_d     = column_q;
        shreg_d      = shreg_q;
        bit_d        = bit_q;
        div_d        = div_q;
        dwell_d      = dwell_q;
        frame_done_d = 1'b0;
        fb_d         = fb_q;
        if (wr_en) fb_d[wr_col] = wr_data;
        unique case (state_q)
            IDLE: state_d = LOAD;
            LOAD: begin
                shreg_d = fb_q[col_q];
                bit_d   = '0;
                div_d   = '0;
                state_d = SHIFT_LO;
            end
            SHIFT_LO: begin
                div_d   = div_done ? '0 : div_q + 1'b1;
                state_d = div_done ? SHIFT_HI : SHIFT_LO;
            end
            SHIFT_HI: begin
                div_d = div_done ? '0 : div_q + 1'b1;
                if (div_done) begin
                    shreg_d = shreg_q << 1;
                    bit_d   = bit_q + 1'b1;
                    state_d = (bit_q == BIT_W'(NUM_ROWS - 1)) ? SETTLE : SHIFT_LO;
                end
            end
            SETTLE: begin
                column_d = col_q;
                dwell_d  = '0;
                state_d  = DISPLAY;
            end
            DISPLAY: begin
                dwell_d = dwell_q + 1'b1;
                if (dwell_done) begin
                    col_d        = col_q + 1'b1;
                    frame_done_d = col_q == COL_W'(NUM_COLS - 1);
                    state_d      = LOAD;
                end
            end
            default: state_d = IDLE;
        endcase
        // Dropping enable abandons any partial shift and restarts the scan at column 0.
        if (!enable) begin
            state_d      = IDLE;
            col_d        = '0;
            frame_done_d = 1'b0;
        end
        row_clk_d   = state_d == SHIFT_HI;
        row_data_d  = (state_d == SHIFT_LO || state_d == SHIFT_HI) && shreg_d[NUM_ROWS-1];
        column_en_d = state_d == DISPLAY;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            col_q        <= '0;
            column_q     <= '0;
            shreg_q      <= '0;
            bit_q        <= '0;
            div_q        <= '0;
            dwell_q      <= '0;
            fb_q         <= '{default: '0};
            row_clk_q    <= 1'b0;
            row_data_q   <= 1'b0;
            column_en_q  <= 1'b0;
            frame_done_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            col_q        <= col_d;
            column_q     <= column_d;
            shreg_q      <= shreg_d;
            bit_q        <= bit_d;
            div_q        <= div_d;
            dwell_q      <= dwell_d;
            fb_q         <= fb_d;
            row_clk_q    <= row_clk_d;
            row_data_q   <= row_data_d;
            column_en_q  <= column_en_d;
            frame_done_q <= frame_done_d;
        end
    end

    btn_debounce #(
        .DEBOUNCE(DEBOUNCE)
    ) u_btn (
        .clk    (clk),
        .rst_n  (rst_n),
        .sample (frame_done_q),
        .code_in(button_code_in),
        .code   (button_code),
        .valid  (button_valid)
    );

    assign row_clk    = row_clk_q;
    assign row_data   = row_data_q;
    assign column     = column_q;
    assign column_en  = column_en_q;
    assign frame_done = frame_done_q;
endmodule

// File: tb/tb_led_scan_ctrl.sv
// tb_led_scan_ctrl: randomized scenarios checked against a CPLD shift-register model,
// a frame-buffer model and a sample-history debounce model.
module tb_led_scan_ctrl;
    localparam int CLK_DIV  = 2;
    localparam int DWELL    = 24;
    localparam int DEBOUNCE = 4;
    localparam int P        = 2 + 32 * CLK_DIV + DWELL;
    localparam int TMO      = 17 * P;

    logic        clk = 0, rst_n = 0, enable = 0, wr_en = 0;
    logic [3:0]  wr_col = 0;
    logic [15:0] wr_data = 0;
    logic        row_clk, row_data, column_en, button_valid, frame_done;
    logic [3:0]  column;
    logic [2:0]  button_code_in = 0, button_code;

    int          compared = 0, mismatched = 0;
    int          cyc = 0, rc_edges = 0, fd_cnt = 0, fd_cyc = 0, overlap = 0;
    logic [15:0] cpld = 0;
    logic        rc_prev = 0;
    logic [15:0] model_fb [16];

    led_scan_ctrl #(.CLK_DIV(CLK_DIV), .DWELL(DWELL), .DEBOUNCE(DEBOUNCE)) dut (
        .clk(clk), .rst_n(rst_n), .enable(enable), .wr_en(wr_en), .wr_col(wr_col),
        .wr_data(wr_data), .row_clk(row_clk), .row_data(row_data), .column(column),
        .column_en(column_en), .button_code_in(button_code_in), .button_code(button_code),
        .button_valid(button_valid), .frame_done(frame_done)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // CPLD row register: shift up, new bit into bit 0 on each rising row_clk
    always @(posedge row_clk) begin
        cpld     <= {cpld[14:0], row_data};
        rc_edges <= rc_edges + 1;
    end

    always @(negedge clk) begin
        if (frame_done) begin
            fd_cnt <= fd_cnt + 1;
            fd_cyc <= cyc;
        end
        if (column_en && (row_clk || row_clk !== rc_prev)) overlap <= overlap + 1;
        rc_prev <= row_clk;
    end

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    task automatic clear_model();
        for (int c = 0; c < 16; c++) model_fb[c] = 16'h0;
    endtask

    task automatic write_fb(input logic [3:0] c, input logic [15:0] d);
        wr_en = 1; wr_col = c; wr_data = d;
        @(posedge clk);
        #1 wr_en = 0;
        model_fb[c] = d;
    endtask

    task automatic wait_en_rise(output bit ok);
        logic p;
        ok = 0;
        p  = column_en;
        for (int i = 0; i < TMO; i++) begin
            @(negedge clk);
            if (column_en && !p) begin ok = 1; break; end
            p = column_en;
        end
    endtask

    task automatic wait_en_fall(output bit ok, output int n);
        ok = 0; n = 0;
        for (int i = 0; i < TMO; i++) begin
            if (!column_en) begin ok = 1; break; end
            n++;
            @(negedge clk);
        end
    endtask

    task automatic wait_rc_hi(output bit ok);
        ok = 0;
        for (int i = 0; i < TMO; i++) begin
            @(negedge clk);
            if (row_clk) begin ok = 1; break; end
        end
    endtask

    task automatic wait_fd(output bit ok);
        ok = 0;
        for (int i = 0; i < TMO; i++) begin
            @(negedge clk);
            if (frame_done) begin ok = 1; break; end
        end
    endtask

    task automatic test_reset();
        bit ok;
        int e;
        rst_n = 0; enable = 0;
        clear_model();
        repeat (3) @(negedge clk);
        compared++;
        if ({row_clk, row_data, column, column_en, button_code, button_valid, frame_done} !== 12'h0) begin
            mismatched++;
            $display("FAIL reset_outputs: got %b want 0", {row_clk, row_data, column, column_en, button_code, button_valid, frame_done});
        end
        rst_n = 1;
        @(negedge clk);
        write_fb(0, 16'h8000 | 16'($urandom));
        enable = 1;
        wait_rc_hi(ok);
        compared++;
        if (!ok) begin mismatched++; $display("FAIL reset_rc_wait: row_clk never rose"); end
        #2 rst_n = 0;
        #1;
        compared++;
        if ({row_clk, row_data, column, column_en, button_code, button_valid, frame_done} !== 12'h0) begin
            mismatched++;
            $display("FAIL async_reset_outputs: got %b want 0", {row_clk, row_data, column, column_en, button_code, button_valid, frame_done});
        end
        e = rc_edges;
        repeat (4) @(negedge clk);
        compared++;
        if (rc_edges !== e || row_clk !== 1'b0) begin
            mismatched++;
            $display("FAIL reset_hold_row_clk: edges %0d want %0d", rc_edges, e);
        end
        enable = 0;
        rst_n  = 1;
        clear_model();
        @(negedge clk);
        enable = 1;
        wait_en_rise(ok);
        compared++;
        if (!ok || cpld !== 16'h0) begin
            mismatched++;
            $display("FAIL reset_fb_cleared: ok=%0d cpld %h want 0000", ok, cpld);
        end
        enable = 0;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_single_column();
        bit ok;
        int e0, n;
        write_fb(0, 16'h0053);
        e0 = rc_edges;
        enable = 1;
        wait_en_rise(ok);
        compared++;
        if (!ok) begin mismatched++; $display("FAIL single_wait: column_en never rose"); end
        compared++;
        if (column !== 4'd0 || cpld !== 16'h0053) begin
            mismatched++;
            $display("FAIL single_word: column %0d cpld %h want column 0 cpld 0053", column, cpld);
        end
        compared++;
        if (rc_edges - e0 !== 16) begin
            mismatched++;
            $display("FAIL single_edges: %0d row_clk edges want 16", rc_edges - e0);
        end
        wait_en_fall(ok, n);
        compared++;
        if (!ok || n !== DWELL) begin
            mismatched++;
            $display("FAIL single_dwell: column_en high %0d cycles want %0d", n, DWELL);
        end
        enable = 0;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_frame();
        bit ok;
        int start, fd0, ov0;
        for (int c = 0; c < 16; c++) write_fb(4'(c), 16'($urandom));
        @(negedge clk);
        enable = 1;
        start  = cyc + 1;
        fd0    = fd_cnt;
        ov0    = overlap;
        for (int k = 0; k <= 16; k++) begin
            wait_en_rise(ok);
            compared++;
            if (!ok || column !== 4'(k % 16) || cpld !== model_fb[k % 16]) begin
                mismatched++;
                $display("FAIL frame_col%0d: ok=%0d column %0d cpld %h want column %0d cpld %h",
                         k, ok, column, cpld, k % 16, model_fb[k % 16]);
            end
        end
        compared++;
        if (fd_cnt - fd0 !== 1) begin
            mismatched++;
            $display("FAIL frame_done_count: %0d pulses want 1", fd_cnt - fd0);
        end
        compared++;
        if (fd_cyc - start !== 16 * P) begin
            mismatched++;
            $display("FAIL frame_done_time: %0d cycles want %0d", fd_cyc - start, 16 * P);
        end
        compared++;
        if (overlap !== ov0) begin
            mismatched++;
            $display("FAIL frame_overlap: %0d cycles with column_en during row_clk activity want 0", overlap - ov0);
        end
        enable = 0;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_enable_drop();
        bit ok;
        int e, n;
        for (int c = 0; c < 16; c++) write_fb(4'(c), 16'($urandom));
        @(negedge clk);
        enable = 1;
        for (int k = 0; k < 5; k++) begin
            wait_en_rise(ok);
            compared++;
            if (!ok) begin mismatched++; $display("FAIL drop_wait_col%0d: timeout", k); end
        end
        wait_en_fall(ok, n);
        wait_rc_hi(ok);
        repeat ($urandom_range(0, CLK_DIV - 1)) @(negedge clk);
        enable = 0;
        @(negedge clk);
        compared++;
        if ({row_clk, row_data, column_en} !== 3'b000 || column !== 4'd4) begin
            mismatched++;
            $display("FAIL drop_idle: row_clk %b row_data %b column_en %b column %0d want 0 0 0 4",
                     row_clk, row_data, column_en, column);
        end
        e = rc_edges;
        repeat (8) @(negedge clk);
        compared++;
        if (rc_edges !== e) begin
            mismatched++;
            $display("FAIL drop_quiet: %0d row_clk edges while idle want 0", rc_edges - e);
        end
        enable = 1;
        wait_en_rise(ok);
        compared++;
        if (!ok || column !== 4'd0 || cpld !== model_fb[0]) begin
            mismatched++;
            $display("FAIL drop_restart: column %0d cpld %h want column 0 cpld %h", column, cpld, model_fb[0]);
        end
        enable = 0;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_load_collision();
        bit ok;
        int n;
        logic [15:0] old_w, new_w;
        @(negedge clk);
        enable = 1;
        for (int k = 0; k < 3; k++) wait_en_rise(ok);
        wait_en_fall(ok, n);
        old_w = model_fb[3];
        new_w = old_w ^ 16'($urandom_range(1, 65535));
        write_fb(3, new_w);
        wait_en_rise(ok);
        compared++;
        if (!ok || column !== 4'd3 || cpld !== old_w) begin
            mismatched++;
            $display("FAIL collide_old: column %0d cpld %h want column 3 cpld %h", column, cpld, old_w);
        end
        for (int k = 1; k <= 16; k++) begin
            wait_en_rise(ok);
            compared++;
            if (!ok || column !== 4'((3 + k) % 16) || cpld !== model_fb[(3 + k) % 16]) begin
                mismatched++;
                $display("FAIL collide_col%0d: column %0d cpld %h want column %0d cpld %h",
                         k, column, cpld, (3 + k) % 16, model_fb[(3 + k) % 16]);
            end
        end
        enable = 0;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_debounce();
        bit ok, pulse, same;
        int seq[$], samples[$];
        logic [2:0] accepted;
        int v, len;
        rst_n = 0; enable = 0;
        repeat (2) @(negedge clk);
        rst_n = 1;
        clear_model();
        seq = '{5, 5, 5, 5, 2, 2, 2, 5, 5, 5, 5};
        while (seq.size() < 17) begin
            v   = $urandom_range(0, 7);
            len = $urandom_range(1, 5);
            for (int i = 0; i < len && seq.size() < 17; i++) seq.push_back(v);
        end
        accepted = 0;
        button_code_in = 3'(seq[0]);
        @(negedge clk);
        enable = 1;
        for (int k = 0; k < seq.size(); k++) begin
            wait_fd(ok);
            compared++;
            if (!ok || button_valid !== 1'b0) begin
                mismatched++;
                $display("FAIL btn_fd%0d: ok=%0d button_valid %b want 0 at frame_done", k, ok, button_valid);
            end
            samples.push_back(seq[k]);
            pulse = 0;
            if (samples.size() >= DEBOUNCE) begin
                same = 1;
                for (int j = samples.size() - DEBOUNCE; j < samples.size(); j++)
                    if (samples[j] != seq[k]) same = 0;
                if (same && 3'(seq[k]) != accepted) begin
                    pulse    = 1;
                    accepted = 3'(seq[k]);
                end
            end
            if (k + 1 < seq.size()) button_code_in = 3'(seq[k + 1]);
            @(negedge clk);
            compared++;
            if ({button_valid, button_code} !== {pulse, accepted}) begin
                mismatched++;
                $display("FAIL btn_frame%0d: valid %b code %0d want valid %b code %0d",
                         k, button_valid, button_code, pulse, accepted);
            end
            @(negedge clk);
            compared++;
            if (button_valid !== 1'b0) begin
                mismatched++;
                $display("FAIL btn_pulse%0d: button_valid %b want 0 one cycle later", k, button_valid);
            end
        end
        enable = 0;
        repeat (2) @(negedge clk);
    endtask

    initial begin
        test_reset();
        test_single_column();
        test_frame();
        test_enable_drop();
        test_load_collision();
        test_debounce();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule
